shift_pipelined: RTL and testbench

Pipelined, parametrised barrel shifter for the datapath ALU: SLL, SRL, SRA and ROR on an N-bit operand, with a configurable number of register stages and a valid/ready handshake on both sides. It accepts one operation per cycle and applies per-stage backpressure with bubble collapsing. It lets the ALU close timing at wide N, where a single-cycle mux tree does not.

---
 rtl/shift_pkg.sv | 9 +
 rtl/shift_level.sv | 18 +
 rtl/shift_pipelined.sv | 90 +++++++++
 tb/tb_shift_pipelined.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared operation encoding for the pipelined barrel shifter.
package shift_pkg;
  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_t;
endpackage

// File: rtl/shift_level.sv
// shift_level: one right-shift level of distance DIST with op-dependent fill.
module shift_level
  import shift_pkg::*;
#(
  parameter int N    = 32,
  parameter int DIST = 1
) (
  input  logic [N-1:0] data,
  input  logic         en,
  input  logic [1:0]   op,
  input  logic         sign,
  output logic [N-1:0] result
);
  logic [DIST-1:0] fill;
  // rotate re-injects the bits falling off the bottom; SLL is already reversed upstream
  assign fill   = op == SHIFT_ROR ? data[DIST-1:0] : op == SHIFT_SRA ? {DIST{sign}} : '0;
  assign result = en ? {fill, data[N-1:DIST]} : data;
endmodule

// File: rtl/shift_pipelined.sv
// shift_pipelined: log2(N)-level barrel shifter split over STAGES registered stages
// with valid/ready handshaking and bubble-collapsing backpressure.
module shift_pipelined
  import shift_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [$clog2(N)-1:0] in_shamt,
  input  logic [1:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data
);
  localparam int L = $clog2(N);
  typedef struct packed {
    logic         valid;
    logic [N-1:0] data;
    logic [L-1:0] shamt;
    shift_op_t    op;
    logic         sign;
  } stage_t;
  function automatic logic [N-1:0] rev(input logic [N-1:0] d);
    for (int b = 0; b < N; b++) rev[b] = d[N-1-b];
  endfunction
  stage_t            st        [STAGES];
  stage_t            src       [STAGES];
  stage_t            nxt       [STAGES];
  logic [N-1:0]      stage_res [STAGES];
  logic [STAGES-1:0] adv;
  assign src[0] = '{valid: in_valid,
                    data:  in_op == SHIFT_SLL ? rev(in_data) : in_data,
                    shamt: in_shamt,
                    op:    shift_op_t'(in_op),
                    sign:  in_data[N-1]};
  genvar s, k;
  for (s = 1; s < STAGES; s++) begin : g_src
    assign src[s] = st[s-1];
  end
  for (k = 0; k < L; k++) begin : g_lvl
    localparam int S     = k * STAGES / L;
    localparam bit FIRST = (k == 0) || ((k - 1) * STAGES / L != S);
    localparam bit LAST  = (k == L - 1) || ((k + 1) * STAGES / L != S);
    logic [N-1:0] d, q;
    if (FIRST) begin : g_first
      assign d = src[S].data;
    end else begin : g_chain
      assign d = g_lvl[k-1].q;
    end
    shift_level #(.N(N), .DIST(1 << k)) u_level (
      .data  (d),
      .en    (src[S].shamt[k]),
      .op    (src[S].op),
      .sign  (src[S].sign),
      .result(q)
    );
    if (LAST) begin : g_out
      assign stage_res[S] = q;
    end
  end
  // undo the entry reversal before the final register so out_data is a pure flop
  for (s = 0; s < STAGES; s++) begin : g_nxt
    logic [N-1:0] res;
    if (s == STAGES - 1) begin : g_exit
      assign res = src[s].op == SHIFT_SLL ? rev(stage_res[s]) : stage_res[s];
    end else begin : g_mid
      assign res = stage_res[s];
    end
    assign nxt[s] = '{valid: src[s].valid, data: res, shamt: src[s].shamt,
                      op: src[s].op, sign: src[s].sign};
  end
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !st[STAGES-1].valid || out_ready;
    for (int i = STAGES - 2; i >= 0; i--) adv[i] = !st[i].valid || adv[i+1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < STAGES; i++) st[i] <= '0;
    else
      for (int i = 0; i < STAGES; i++) if (adv[i]) st[i] <= nxt[i];
  assign in_ready  = adv[0];
  assign out_valid = st[STAGES-1].valid;
  assign out_data  = st[STAGES-1].data;
endmodule

// File: tb/tb_shift_pipelined.sv
// tb_shift_pipelined: directed handshake tests on N=32/STAGES=2 plus a randomised
// scoreboard sweep over four width/depth configurations.
module tb_shift_pipelined;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv   [4];
  logic        ordy [4];
  logic [63:0] idat [4];
  logic [5:0]  ish  [4];
  logic [1:0]  iop  [4];
  logic        ir   [4];
  logic        ov   [4];
  logic [63:0] od   [4];
  logic [31:0] od0;
  logic [7:0]  od1, od2;
  logic [63:0] od3;
  int          checks = 0;
  int          fails = 0;
  int          nw [4] = '{32, 8, 8, 64};
  logic [63:0] sb [4][$];

  always #5 clk = ~clk;

  assign od[0] = {32'b0, od0};
  assign od[1] = {56'b0, od1};
  assign od[2] = {56'b0, od2};
  assign od[3] = od3;

  shift_pipelined #(.N(32), .STAGES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0][31:0]),
    .in_shamt(ish[0][4:0]), .in_op(iop[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0));
  shift_pipelined #(.N(8), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1][7:0]),
    .in_shamt(ish[1][2:0]), .in_op(iop[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1));
  shift_pipelined #(.N(8), .STAGES(3)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idat[2][7:0]),
    .in_shamt(ish[2][2:0]), .in_op(iop[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2));
  shift_pipelined #(.N(64), .STAGES(6)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(idat[3]),
    .in_shamt(ish[3]), .in_op(iop[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od3));

  // Reference: shift semantics on an n-bit value using plain arithmetic.
  function automatic logic [63:0] ref_shift(int n, logic [1:0] op, int sh, logic [63:0] d);
    logic [63:0] m;
    m = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    d = d & m;
    case (op)
      2'd0:    return (d << sh) & m;
      2'd1:    return d >> sh;
      2'd2:    return (d >> sh) | (d[n-1] ? (m & ~(m >> sh)) : 64'd0);
      default: return ((d >> sh) | (d << (n - sh))) & m;
    endcase
  endfunction

  task automatic drive0(input logic v, input logic [1:0] op, input logic [5:0] sh, input logic [63:0] d);
    iv[0] = v; iop[0] = op; ish[0] = sh; idat[0] = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (ov[j] !== 1'b0 || od[j] !== 64'd0) begin
        fails++;
        $display("FAIL reset[%0d]: out_valid=%b out_data=%h, required 0/0", j, ov[j], od[j]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (ir[j] !== 1'b1) begin
        fails++;
        $display("FAIL reset_ready[%0d]: in_ready=%b, required 1", j, ir[j]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_sequence;
    logic [1:0]  op [3] = '{2'd0, 2'd1, 2'd2};
    logic [5:0]  sh [3] = '{6'd31, 6'd31, 6'd4};
    logic [63:0] d  [3] = '{64'h1, 64'h8000_0000, 64'h8000_0000};
    logic [63:0] e  [3] = '{64'h8000_0000, 64'h1, 64'hF800_0000};
    ordy[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive0(1'b1, op[c], sh[c], d[c]);
      else drive0(1'b0, 2'd0, 6'd0, 64'd0);
      #1;
      checks++;
      if (c >= 2 && c < 5) begin
        if (ov[0] !== 1'b1 || od[0] !== e[c-2]) begin
          fails++;
          $display("FAIL seq[%0d]: valid=%b data=%h, required 1/%h", c, ov[0], od[0], e[c-2]);
        end
      end else if (ov[0] !== 1'b0) begin
        fails++;
        $display("FAIL seq_idle[%0d]: valid=%b, required 0", c, ov[0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_shifts;
    logic [1:0]  op [7] = '{2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
    logic [5:0]  sh [7] = '{6'd1, 6'd8, 6'd0, 6'd0, 6'd0, 6'd0, 6'd4};
    logic [63:0] d  [7] = '{64'h1, 64'h1234_5678, 64'hDEAD_BEEF, 64'hDEAD_BEEF,
                            64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'h7000_0000};
    logic [63:0] e  [7] = '{64'h8000_0000, 64'h7812_3456, 64'hDEAD_BEEF, 64'hDEAD_BEEF,
                            64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'h0700_0000};
    ordy[0] = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c < 7) drive0(1'b1, op[c], sh[c], d[c]);
      else drive0(1'b0, 2'd0, 6'd0, 64'd0);
      #1;
      if (c >= 2) begin
        checks++;
        if (ov[0] !== 1'b1 || od[0] !== e[c-2]) begin
          fails++;
          $display("FAIL shift[%0d]: valid=%b data=%h, required 1/%h", c - 2, ov[0], od[0], e[c-2]);
        end
      end
      @(negedge clk);
    end
    drive0(1'b0, 2'd0, 6'd0, 64'd0);
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int          idx = 0;
    logic [63:0] got [$];
    ordy[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive0(idx < 4, 2'd0, 6'(idx), 64'h1);
      #1;
      if (c >= 3) begin
        checks++;
        if (ov[0] !== 1'b1 || od[0] !== 64'h1) begin
          fails++;
          $display("FAIL bp_hold[%0d]: valid=%b data=%h, required 1/1", c, ov[0], od[0]);
        end
      end
      if (ir[0]) idx++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (idx !== 2 || ir[0] !== 1'b0) begin
      fails++;
      $display("FAIL bp_full: accepts=%0d in_ready=%b, required 2/0", idx, ir[0]);
    end
    ordy[0] = 1'b1;
    #1;
    checks++;
    if (ir[0] !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: in_ready=%b, required 1", ir[0]);
    end
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      drive0(idx < 4, 2'd0, 6'(idx), 64'h1);
      #1;
      if (ov[0]) got.push_back(od[0]);
      if (ir[0] && iv[0]) idx++;
      @(negedge clk);
    end
    drive0(1'b0, 2'd0, 6'd0, 64'd0);
    checks++;
    if (got.size() != 4) begin
      fails++;
      $display("FAIL bp_count: outputs=%0d, required 4", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== (64'd1 << i)) begin
        fails++;
        $display("FAIL bp_order[%0d]: data=%h, required %h", i, got[i], 64'd1 << i);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_bubble;
    logic [63:0] got [$];
    ordy[0] = 1'b0;
    drive0(1'b1, 2'd1, 6'd4, 64'hF0);
    #1;
    checks++;
    if (ir[0] !== 1'b1) begin
      fails++;
      $display("FAIL bubble_a: in_ready=%b, required 1", ir[0]);
    end
    @(negedge clk);
    drive0(1'b0, 2'd0, 6'd0, 64'd0);
    @(negedge clk);
    drive0(1'b1, 2'd0, 6'd2, 64'h3);
    #1;
    checks++;
    if (ir[0] !== 1'b1) begin
      fails++;
      $display("FAIL bubble_b: in_ready=%b, required 1", ir[0]);
    end
    @(negedge clk);
    drive0(1'b0, 2'd0, 6'd0, 64'd0);
    #1;
    checks++;
    if (ir[0] !== 1'b0 || ov[0] !== 1'b1 || od[0] !== 64'hF) begin
      fails++;
      $display("FAIL bubble_full: ready=%b valid=%b data=%h, required 0/1/f", ir[0], ov[0], od[0]);
    end
    ordy[0] = 1'b1;
    for (int c = 0; c < 10 && got.size() < 2; c++) begin
      #1;
      if (ov[0]) got.push_back(od[0]);
      @(negedge clk);
    end
    checks++;
    if (got.size() != 2 || got[0] !== 64'hF || got[1] !== 64'hC) begin
      fails++;
      $display("FAIL bubble_drain: count=%0d, required 2 outputs f then c", got.size());
    end
  endtask

  task automatic test_reset_mid;
    int late = 0;
    ordy[0] = 1'b1;
    drive0(1'b1, 2'd1, 6'd1, 64'hFF);
    @(negedge clk);
    drive0(1'b1, 2'd0, 6'd1, 64'h3);
    @(negedge clk);
    drive0(1'b0, 2'd0, 6'd0, 64'd0);
    #1;
    checks++;
    if (ov[0] !== 1'b1 || od[0] !== 64'h7F) begin
      fails++;
      $display("FAIL rmid_pre: valid=%b data=%h, required 1/7f", ov[0], od[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || od[0] !== 64'd0) begin
      fails++;
      $display("FAIL rmid_now: valid=%b data=%h, required 0/0", ov[0], od[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (ov[0]) late++;
      @(negedge clk);
    end
    checks++;
    if (late != 0) begin
      fails++;
      $display("FAIL rmid_after: outputs=%0d, required 0", late);
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 3000; c++) begin
      for (int j = 0; j < 4; j++) begin
        logic [63:0] m;
        m = (nw[j] == 64) ? '1 : ((64'd1 << nw[j]) - 64'd1);
        iv[j]   = (c < 2960) && ($urandom_range(0, 9) < 7);
        ordy[j] = $urandom_range(0, 9) < 6 || c >= 2960;
        iop[j]  = 2'($urandom_range(0, 3));
        ish[j]  = 6'($urandom_range(0, nw[j] - 1));
        idat[j] = {$urandom, $urandom} & m;
      end
      #1;
      for (int j = 0; j < 4; j++) begin
        if (ov[j] && ordy[j]) begin
          checks++;
          if (sb[j].size() == 0) begin
            fails++;
            $display("FAIL rand_extra[%0d]: data=%h, required no output", j, od[j]);
          end else begin
            logic [63:0] e;
            e = sb[j].pop_front();
            if (od[j] !== e) begin
              fails++;
              $display("FAIL rand[%0d]: data=%h, required %h", j, od[j], e);
            end
          end
        end
        if (iv[j] && ir[j]) sb[j].push_back(ref_shift(nw[j], iop[j], int'(ish[j]), idat[j]));
      end
      @(negedge clk);
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (sb[j].size() != 0) begin
        fails++;
        $display("FAIL rand_lost[%0d]: pending=%0d, required 0", j, sb[j].size());
      end
    end
  endtask

  initial begin
    for (int j = 0; j < 4; j++) begin
      iv[j] = 1'b0; ordy[j] = 1'b1; idat[j] = '0; ish[j] = '0; iop[j] = '0;
    end
    test_reset();
    test_sequence();
    test_shifts();
    test_backpressure();
    test_bubble();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
